data_memory: RTL and testbench



---
 rtl/data_memory_pkg.sv | 20 ++
 rtl/data_memory_byte_array.sv | 38 +++
 rtl/data_memory.sv | 71 +++++++
 tb/tb_data_memory.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/data_memory_pkg.sv
// Shared types and constants for the 24-bit CPU data memory.
// Word = three big-endian bytes.
package data_memory_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 24;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;

  // Byte p of a word, p = 0 being the most significant.
  function automatic byte_t word_byte(
    input word_t w,
    input int    p
  );
    return w[WORD_W-1-BYTE_W*p -: BYTE_W];
  endfunction

endpackage

// File: rtl/data_memory_byte_array.sv
// Byte storage with synchronous clear, three write and three read ports.
// Indices are already wrapped to the array depth by the caller.
module data_memory_byte_array
  import data_memory_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr [BYTES_PER_WORD],
  input  byte_t                wdata [BYTES_PER_WORD],
  input  logic [ADDR_BITS-1:0] raddr [BYTES_PER_WORD],
  output byte_t                rdata [BYTES_PER_WORD]
);

  localparam int DEPTH = 1 << ADDR_BITS;

  byte_t mem [DEPTH];

  // Reset wins over a write on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int p = 0; p < BYTES_PER_WORD; p++) begin
        mem[waddr[p]] <= wdata[p];
      end
    end
  end

  for (genvar p = 0; p < BYTES_PER_WORD; p++) begin : g_rd
    assign rdata[p] = mem[raddr[p]];
  end

endmodule

// File: rtl/data_memory.sv
// MEM-stage data memory: word split/join, read gating, optional range check.
// Optional feature: DATA_MEMORY_RANGE_CHECK_EN adds AddrErr.
module data_memory #(
  parameter int ADDR_BITS = 8,
  parameter int WORD_W    = 24
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [23:0]       Address,
  input  logic [WORD_W-1:0] WriteData,
  input  logic              MemWrite,
  input  logic              MemRead,
  output logic [WORD_W-1:0] ReadData
`ifdef DATA_MEMORY_RANGE_CHECK_EN
  ,
  output logic              AddrErr
`endif
);

  import data_memory_pkg::*;

  localparam int NB    = BYTES_PER_WORD;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS-1:0] idx [NB];
  byte_t                wbytes [NB];
  byte_t                rbytes [NB];
  word_t                rword;
  logic                 err;
  logic                 wr_en;
  logic                 rd_en;

  assign base = Address[ADDR_BITS-1:0];

  // Consecutive bytes wrap naturally through the narrow index width.
  for (genvar p = 0; p < NB; p++) begin : g_lane
    assign idx[p]    = base + ADDR_BITS'(p);
    assign wbytes[p] = word_byte(WriteData, p);
    assign rword[WORD_W-1-BYTE_W*p -: BYTE_W] = rbytes[p];
  end

`ifdef DATA_MEMORY_RANGE_CHECK_EN
  localparam logic [23:0] LIMIT = 24'(DEPTH - (NB - 1));

  assign err     = (MemRead | MemWrite) & (Address >= LIMIT);
  assign AddrErr = err;
`else
  logic addr_unused;

  assign err         = 1'b0;
  assign addr_unused = ^Address[23:ADDR_BITS];
`endif

  assign wr_en    = MemWrite & ~err;
  assign rd_en    = MemRead & ~err;
  assign ReadData = rd_en ? rword : '0;

  data_memory_byte_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clock(Clock),
    .reset(Reset),
    .we   (wr_en),
    .waddr(idx),
    .wdata(wbytes),
    .raddr(idx),
    .rdata(rbytes)
  );

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus pushes expectations,
// a monitor pops and compares ReadData (and AddrErr when enabled).
module tb_data_memory;

  logic        Clock;
  logic        Reset;
  logic [23:0] Address;
  logic [23:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [23:0] ReadData;
`ifdef DATA_MEMORY_RANGE_CHECK_EN
  logic        AddrErr;
`endif

  typedef struct {
    logic [23:0] rd;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  data_memory dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .ReadData (ReadData)
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    ,
    .AddrErr  (AddrErr)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Monitor: inputs settle at negedge+1, compared at negedge+2.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (ReadData !== e.rd) begin
          n_fail++;
          $display("FAIL %s: ReadData got %h want %h",
                   e.name, ReadData, e.rd);
        end
`ifdef DATA_MEMORY_RANGE_CHECK_EN
        n_tests++;
        if (AddrErr !== e.err) begin
          n_fail++;
          $display("FAIL %s: AddrErr got %b want %b",
                   e.name, AddrErr, e.err);
        end
`endif
      end
    end
  end

  task automatic cyc(
    input logic        rst,
    input logic        we,
    input logic        rd,
    input logic [23:0] addr,
    input logic [23:0] data,
    input logic        chk,
    input logic [23:0] exp_rd,
    input logic        exp_err,
    input string       name
  );
    exp_t e;
    @(negedge Clock);
    Reset     = rst;
    MemWrite  = we;
    MemRead   = rd;
    Address   = addr;
    WriteData = data;
    #1;
    if (chk) begin
      e.rd   = exp_rd;
      e.err  = exp_err;
      e.name = name;
      sb.push_back(e);
    end
    @(posedge Clock);
    #1;
    Reset    = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  task automatic rd_chk(
    input logic [23:0] addr,
    input logic [23:0] exp_rd,
    input logic        exp_err,
    input string       name
  );
    cyc(1'b0, 1'b0, 1'b1, addr, 24'h0, 1'b1, exp_rd, exp_err, name);
  endtask

  task automatic wr(
    input logic [23:0] addr,
    input logic [23:0] data
  );
    cyc(1'b0, 1'b1, 1'b0, addr, data, 1'b0, 24'h0, 1'b0, "");
  endtask

  initial begin
    Reset     = 1'b0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    Address   = '0;
    WriteData = '0;

    cyc(1'b1, 1'b0, 1'b0, 24'd0, 24'h0, 1'b0, 24'h0, 1'b0, "");
    rd_chk(24'd0,   24'h000000, 1'b0, "rst_rd0");
    rd_chk(24'd200, 24'h000000, 1'b0, "rst_rd200");

    wr(24'd16, 24'd2);
    rd_chk(24'd16, 24'h000002, 1'b0, "wr2_rd16");
    rd_chk(24'd10, 24'h000000, 1'b0, "wr2_rd10");
    cyc(1'b0, 1'b0, 1'b0, 24'd16, 24'h0, 1'b1,
        24'h000000, 1'b0, "rd_off");

    wr(24'd16, 24'hABCDEF);
    rd_chk(24'd16, 24'hABCDEF, 1'b0, "rd16");
    rd_chk(24'd17, 24'hCDEF00, 1'b0, "rd17");
    rd_chk(24'd15, 24'h00ABCD, 1'b0, "rd15");

    cyc(1'b0, 1'b1, 1'b0, 24'd255, 24'h123456, 1'b1,
        24'h000000, 1'b1, "wr255_flag");
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    rd_chk(24'd255,   24'h000000, 1'b1, "wrap_rd255");
    rd_chk(24'd0,     24'h000000, 1'b0, "wrap_rd0");
    rd_chk(24'd254,   24'h000000, 1'b1, "wrap_rd254");
    rd_chk(24'h000110, 24'h000000, 1'b1, "alias_rd");
`else
    rd_chk(24'd255,   24'h123456, 1'b0, "wrap_rd255");
    rd_chk(24'd0,     24'h345600, 1'b0, "wrap_rd0");
    rd_chk(24'd254,   24'h001234, 1'b0, "wrap_rd254");
    rd_chk(24'h000110, 24'hABCDEF, 1'b0, "alias_rd");
`endif

    cyc(1'b0, 1'b1, 1'b1, 24'd40, 24'h111111, 1'b1,
        24'h000000, 1'b0, "rw_old");
    rd_chk(24'd40, 24'h111111, 1'b0, "rw_new");

    cyc(1'b1, 1'b1, 1'b0, 24'd4, 24'hFFFFFF, 1'b0,
        24'h0, 1'b0, "");
    rd_chk(24'd4,  24'h000000, 1'b0, "rst_wr4");
    rd_chk(24'd16, 24'h000000, 1'b0, "rst_clr16");
    rd_chk(24'd40, 24'h000000, 1'b0, "rst_clr40");

    cyc(1'b0, 1'b1, 1'b0, 24'd253, 24'hAABBCC, 1'b1,
        24'h000000, 1'b0, "wr253_flag");
    rd_chk(24'd253, 24'hAABBCC, 1'b0, "rd253");
    cyc(1'b0, 1'b1, 1'b0, 24'd254, 24'hDDEEFF, 1'b1,
        24'h000000, 1'b1, "wr254_flag");
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    rd_chk(24'd253, 24'hAABBCC, 1'b0, "rd253_after");
    rd_chk(24'd0,   24'h000000, 1'b0, "rd0_after");
    rd_chk(24'd254, 24'h000000, 1'b1, "rd254_after");
`else
    rd_chk(24'd253, 24'hAADDEE, 1'b0, "rd253_after");
    rd_chk(24'd0,   24'hFF0000, 1'b0, "rd0_after");
    rd_chk(24'd254, 24'hDDEEFF, 1'b0, "rd254_after");
`endif

    repeat (3) @(posedge Clock);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: %0d left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
